// File: rtl/spi_slave_sync_if.sv
// Pin and stream bundle for spi_slave_sync: SPI pins, TX/RX valid/ready ports and status.
interface spi_slave_sync_if #(
  parameter int unsigned DWIDTH = 8
);
  logic              ss_n;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DWIDTH-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  ss_n, sclk, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, frame_err, busy
  );

  modport master (
    output ss_n, sclk, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave running entirely on clk; oversamples the SPI pins.
// Define SPI_SLV_SYNC_EN to put 2-FF synchronisers on ss_n/sclk/mosi.
module spi_slave_sync #(
  parameter int unsigned       DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] TX_IDLE = {DWIDTH{1'b1}}
) (
  input logic             clk,
  input logic             rst,
  spi_slave_sync_if.slave bus
);
  localparam int unsigned    CW   = $clog2(DWIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DWIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic ss_s, sclk_s, mosi_s;

`ifdef SPI_SLV_SYNC_EN
  logic [1:0] ss_sync, sclk_sync, mosi_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[0], bus.ss_n};
      sclk_sync <= {sclk_sync[0], bus.sclk};
      mosi_sync <= {mosi_sync[0], bus.mosi};
    end
  end

  assign ss_s   = ss_sync[1];
  assign sclk_s = sclk_sync[1];
  assign mosi_s = mosi_sync[1];
`else
  assign ss_s   = bus.ss_n;
  assign sclk_s = bus.sclk;
  assign mosi_s = bus.mosi;
`endif

  logic ss_q, sclk_q, sel_q;
  logic ss_fall, sclk_rise, sclk_fall;

  assign ss_fall   = ss_q & ~ss_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  state_t            state, state_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [DWIDTH-1:0] rx_sh, rx_sh_n;
  logic [DWIDTH-1:0] tx_sh, tx_sh_n;
  logic [DWIDTH-1:0] rx_data, rx_data_n;
  logic              rx_valid, rx_valid_n;
  logic              tx_ready, tx_ready_n;
  logic              overrun, overrun_n;
  logic              frame_err, frame_err_n;
  logic              load_c;

  // Edge-detect history, select flag and all datapath/state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      sel_q     <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ss_q      <= ss_s;
      sclk_q    <= sclk_s;
      sel_q     <= ~ss_s;
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_sh     <= rx_sh_n;
      tx_sh     <= tx_sh_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_ready  <= tx_ready_n;
      overrun   <= overrun_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    rx_sh_n     = rx_sh;
    tx_sh_n     = tx_sh;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid;
    tx_ready_n  = 1'b0;
    overrun_n   = 1'b0;
    frame_err_n = 1'b0;
    load_c      = 1'b0;

    if (rx_valid && bus.rx_ready) rx_valid_n = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        if (ss_fall) state_n = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: begin
        // Deselect wins over any sclk edge seen in the same cycle
        if (ss_s) begin
          state_n     = IDLE;
          bit_cnt_n   = '0;
          frame_err_n = (bit_cnt != '0);
        end else if (sclk_rise) begin
          rx_sh_n = {rx_sh[DWIDTH-2:0], mosi_s};
          if (bit_cnt == LAST) begin
            bit_cnt_n = '0;
            if (!rx_valid || bus.rx_ready) begin
              rx_data_n  = {rx_sh[DWIDTH-2:0], mosi_s};
              rx_valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt != '0) tx_sh_n = {tx_sh[DWIDTH-2:0], 1'b0};
          else               load_c  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Word boundary: take the next TX word or fall back to the idle pattern
    if (load_c) begin
      if (bus.tx_valid) begin
        tx_sh_n    = bus.tx_data;
        tx_ready_n = 1'b1;
      end else begin
        tx_sh_n = TX_IDLE;
      end
    end
  end

  assign bus.miso      = tx_sh[DWIDTH-1];
  assign bus.miso_oe   = sel_q;
  assign bus.busy      = sel_q;
  assign bus.tx_ready  = tx_ready;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err;
endmodule
